regfile_sequencer: RTL
======================

// Module: regfile_sequencer
// PURPOSE
//  Initiator side of the register-file/ALU datapath: accepts queued commands, drives read1/read2,
//  ALU op/shft, captures the combinational ALU result and issues the write-back (wrtEn/wrtAdd/data).
//  Sits between the instruction source and Register + ALU; replaces bench-driven register traffic.
// PARAMETERS
//  FIFO_DEPTH  2  command queue entries (power of 2, >=2)
//  PROTECT_R0  1  1: writes to address 0 suppressed
//  OVF_BLOCK   1  1: add/sub with overflow suppresses write-back
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   async active-low reset
//  cmd_valid    in   1   command offered
//  cmd_ready    out  1   queue can accept (= !full)
//  cmd_op       in   4   ALU op 0..8 (add,sub,and,or,sll,srl,sra,max,min)
//  cmd_imm_sel  in   1   1: load-immediate (write cmd_imm, ALU unused)
//  cmd_rs       in   5   source A address
//  cmd_rt       in   5   source B address
//  cmd_rd       in   5   destination address
//  cmd_shft     in   5   shift amount
//  cmd_imm      in   32  immediate data
//  read1,read2  out  5   register-file read addresses
//  alu_op       out  4   to ALU op
//  alu_shft     out  5   to ALU shft
//  alu_result   in   32  ALU Result (signed)
//  alu_ovf      in   1   ALU overflow (only ==1'b1 counts; 0/x = no overflow)
//  wrt_en       out  1   register write enable
//  wrt_add      out  5   write address
//  wrt_data     out  32  write data
//  busy         out  1   FSM not IDLE or queue non-empty
//  done         out  1   1-cycle completion pulse
//  done_rd      out  5   rd of completed command
//  done_result  out  32  result of completed command
//  done_ovf     out  1   overflow flag of completed command
//  done_wrote   out  1   write-back actually performed
//  done_err     out  1   illegal op (9..15 with imm_sel=0)
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; queue flushed; FSM=IDLE. Async assert, sync release.
//  Queue: push on cmd_valid&&cmd_ready; pop on entry to ISSUE; FIFO order; no push when full even if pop same cycle.
//  FSM: IDLE -(queue non-empty)-> ISSUE -> WRITE -(queue non-empty)-> ISSUE | -> IDLE.
//  ISSUE (1 cycle): read1=rs, read2=rt, alu_op=op, alu_shft=shft registered outputs; at cycle end
//   latch result = imm_sel ? cmd_imm : alu_result; ovf = (op<=1 && !imm_sel && alu_ovf==1'b1).
//  WRITE (1 cycle): wrt_add=rd, wrt_data=latched result, wrt_en=1 unless
//   (PROTECT_R0 && rd==0) || (OVF_BLOCK && ovf) || err. done=1 with done_* valid this cycle only.
//  read1/read2/alu_op held through WRITE; wrt_en is 0 in every other state.
//  Latency: accept at edge N -> ISSUE cycle N+1 -> WRITE cycle N+2; register updated at end of N+2.
//  Throughput: one command per 2 cycles; back-to-back RAW safe (write lands before next ISSUE).
//  Arithmetic: 32-bit signed, no extension; immediate passed unchanged.
//  Reset mid-operation: wrt_en and done drop immediately; in-flight and queued commands discarded.
// TESTING
//  1 Post-reset (reg[i]=i): add rd=3 rs=5 rt=6 -> WRITE cycle wrt_en=1 wrt_add=3 wrt_data=11, done=1.
//  2 LI rd=10 imm=-20 then sra rd=11 rs=10 shft=2 -> writes 0xFFFFFFEC then 0xFFFFFFFB (-5).
//  3 LI r1=0x7FFFFFFF; add rd=2 rs=1 rt=1 -> done_ovf=1, done_wrote=0, wrt_en stays 0, r2 remains 2.
//  4 LI rd=0 imm=7 -> done=1, done_wrote=0, wrt_en=0; op=12 imm_sel=0 -> done_err=1, no write.
//  5 Push 4 cmds every cycle, FIFO_DEPTH=2: cmd_ready drops when full; add r3=r5+r6, add r4=r3+r3 -> 11, 22 in order.
//  6 Assert rst_n low during WRITE -> wrt_en=0 same cycle, no done, busy=0, cmd_ready=1 after release.

Source files
------------

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: queued command sequencer driving register-file reads, ALU op/shift and write-back. Ports: clk, rst_n (async low), cmd_* in / cmd_ready out, read1/read2/alu_op/alu_shft out, alu_result/alu_ovf in, wrt_en/wrt_add/wrt_data out, busy, done and done_* status out.
module regfile_sequencer #(
  parameter int FIFO_DEPTH = 2,
  parameter bit PROTECT_R0 = 1'b1,
  parameter bit OVF_BLOCK  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic        cmd_imm_sel,
  input  logic [4:0]  cmd_rs,
  input  logic [4:0]  cmd_rt,
  input  logic [4:0]  cmd_rd,
  input  logic [4:0]  cmd_shft,
  input  logic [31:0] cmd_imm,
  output logic [4:0]  read1,
  output logic [4:0]  read2,
  output logic [3:0]  alu_op,
  output logic [4:0]  alu_shft,
  input  logic [31:0] alu_result,
  input  logic        alu_ovf,
  output logic        wrt_en,
  output logic [4:0]  wrt_add,
  output logic [31:0] wrt_data,
  output logic        busy,
  output logic        done,
  output logic [4:0]  done_rd,
  output logic [31:0] done_result,
  output logic        done_ovf,
  output logic        done_wrote,
  output logic        done_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef struct packed {
    logic [3:0]  op;
    logic        imm_sel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shft;
    logic [31:0] imm;
  } cmd_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WRITE} state_t;
  state_t      state, state_nx;
  cmd_t        mem [FIFO_DEPTH];
  cmd_t        head;
  logic [AW:0] wp, rp;
  logic [1:0]  rst_sync;
  logic        srst_n, empty, full, push, pop, wrt_ok;
  logic        imm_sel_q, err_q, ovf_q;
  logic [4:0]  rd_q;
  logic [31:0] imm_q, res_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign srst_n    = rst_sync[1];
  assign empty     = wp == rp;
  assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem[rp[AW-1:0]];
  always_comb begin
    state_nx = state == ISSUE ? WRITE : (!empty ? ISSUE : IDLE);
    pop      = state_nx == ISSUE;
  end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= '{cmd_op, cmd_imm_sel, cmd_rs, cmd_rt, cmd_rd, cmd_shft, cmd_imm};
  always_ff @(posedge clk or negedge srst_n)
    if (!srst_n) begin
      state     <= IDLE;
      wp        <= '0;
      rp        <= '0;
      read1     <= '0;
      read2     <= '0;
      alu_op    <= '0;
      alu_shft  <= '0;
      rd_q      <= '0;
      imm_sel_q <= 1'b0;
      imm_q     <= '0;
      err_q     <= 1'b0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp        <= rp + 1'b1;
        read1     <= head.rs;
        read2     <= head.rt;
        alu_op    <= head.op;
        alu_shft  <= head.shft;
        rd_q      <= head.rd;
        imm_sel_q <= head.imm_sel;
        imm_q     <= head.imm;
        err_q     <= !head.imm_sel && head.op > 4'd8;
      end
      if (state == ISSUE) begin
        res_q <= imm_sel_q ? imm_q : alu_result;
        ovf_q <= alu_op <= 4'd1 && !imm_sel_q && (alu_ovf === 1'b1);
      end
    end
  assign wrt_ok      = !((PROTECT_R0 && rd_q == 5'd0) || (OVF_BLOCK && ovf_q) || err_q);
  assign done        = state == WRITE;
  assign wrt_en      = done && wrt_ok;
  assign wrt_add     = done ? rd_q : '0;
  assign wrt_data    = done ? res_q : '0;
  assign busy        = state != IDLE || !empty;
  assign done_rd     = done ? rd_q : '0;
  assign done_result = done ? res_q : '0;
  assign done_ovf    = done && ovf_q;
  assign done_wrote  = wrt_en;
  assign done_err    = done && err_q;
endmodule
